// File: rtl/gearbox_param.sv
// gearbox_param: word-granular width converter between two beat widths.
// Words flow through a circular buffer of DEPTH_WORDS entries. Each word carries
// its own error flag. Fill level, upstream/downstream handshakes and a sticky
// overflow flag are provided. flush clears pointers, fill, error flags and
// overflow synchronously.
module gearbox_param #(
    parameter int WORDSIZE    = 16,
    parameter int IN_WORDS    = 4,
    parameter int OUT_WORDS   = 3,
    parameter int DEPTH_WORDS = 40,
    parameter int CNTW        = 6
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_enable,
    input  logic                            flush,
    input  logic [IN_WORDS*WORDSIZE-1:0]    in_data,
    input  logic                            in_datavalid,
    input  logic                            in_dataerror,
    output logic                            out_idle,
    output logic [OUT_WORDS*WORDSIZE-1:0]   out_data,
    output logic                            out_datavalid,
    output logic                            out_dataerror,
    input  logic                            in_idle,
    output logic [CNTW-1:0]                 fill_level,
    output logic                            overflow
);

    localparam int PW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [WORDSIZE-1:0]    mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] err_flags;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CNTW-1:0]        fill;
    logic                   overflow_q;
    logic                   room;
    logic                   push;
    logic                   pop;

    // Pointer advance with wrap; n is always below DEPTH_WORDS so one subtraction suffices,
    // which keeps non-power-of-two depths legal.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input int n);
        int s;
        s = int'(ptr) + n;
        if (s >= DEPTH_WORDS) begin
            s = s - DEPTH_WORDS;
        end
        return PW'(s);
    endfunction

    // Room for a whole input beat; a pop in the same cycle is deliberately not credited.
    assign room          = (int'(fill) + IN_WORDS) <= DEPTH_WORDS;
    assign out_idle      = in_enable & room;
    assign out_datavalid = in_enable & (int'(fill) >= OUT_WORDS);
    assign push          = in_enable & in_datavalid & room;
    assign pop           = out_datavalid & in_idle;
    assign fill_level    = fill;
    assign overflow      = overflow_q;

    // Combinational read of OUT_WORDS words starting at the oldest buffered word.
    always_comb begin
        out_data      = '0;
        out_dataerror = 1'b0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            out_data[k*WORDSIZE +: WORDSIZE] = mem[ptr_add(rd_ptr, k)];
            out_dataerror                    = out_dataerror | err_flags[ptr_add(rd_ptr, k)];
        end
    end

    // Control state: pointers, fill count, per-word error flags and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            err_flags  <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            err_flags  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_add(wr_ptr, IN_WORDS);
                for (int i = 0; i < IN_WORDS; i++) begin
                    err_flags[ptr_add(wr_ptr, i)] <= in_dataerror;
                end
            end
            if (pop) begin
                rd_ptr <= ptr_add(rd_ptr, OUT_WORDS);
            end
            fill <= fill + (push ? CNTW'(IN_WORDS) : '0) - (pop ? CNTW'(OUT_WORDS) : '0);
            if (in_enable && in_datavalid && !room) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Word storage: a beat lands at wr_ptr..wr_ptr+IN_WORDS-1, wrapping freely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            for (int i = 0; i < IN_WORDS; i++) begin
                mem[ptr_add(wr_ptr, i)] <= in_data[i*WORDSIZE +: WORDSIZE];
            end
        end
    end

endmodule

// File: tb/tb_gearbox_param.sv
// tb_gearbox_param: directed bench for gearbox_param in 64->48 and 48->64 configurations.
module tb_gearbox_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_enable, flush, in_datavalid, in_dataerror, in_idle;
    logic [63:0] in_data;
    logic        out_idle, out_datavalid, out_dataerror, overflow;
    logic [47:0] out_data;
    logic [5:0]  fill_level;

    logic        in_enable5, flush5, in_datavalid5, in_dataerror5, in_idle5;
    logic [47:0] in_data5;
    logic        out_idle5, out_datavalid5, out_dataerror5, overflow5;
    logic [63:0] out_data5;
    logic [4:0]  fill_level5;

    int passed = 0;
    int total  = 0;

    logic [47:0] cap_d[$];
    logic        cap_e[$];
    logic [63:0] cap5_d[$];

    logic [63:0] beats[3] = '{64'h0003_0002_0001_0000, 64'h0007_0006_0005_0004, 64'h000B_000A_0009_0008};
    logic [47:0] exp_o[4] = '{48'h0002_0001_0000, 48'h0005_0004_0003, 48'h0008_0007_0006, 48'h000B_000A_0009};
    logic [3:0]  exp_err_b1 = 4'b0110;

    gearbox_param dut (
        .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .flush(flush),
        .in_data(in_data), .in_datavalid(in_datavalid), .in_dataerror(in_dataerror),
        .out_idle(out_idle), .out_data(out_data), .out_datavalid(out_datavalid),
        .out_dataerror(out_dataerror), .in_idle(in_idle), .fill_level(fill_level),
        .overflow(overflow)
    );

    gearbox_param #(.WORDSIZE(16), .IN_WORDS(3), .OUT_WORDS(4), .DEPTH_WORDS(24), .CNTW(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .in_enable(in_enable5), .flush(flush5),
        .in_data(in_data5), .in_datavalid(in_datavalid5), .in_dataerror(in_dataerror5),
        .out_idle(out_idle5), .out_data(out_data5), .out_datavalid(out_datavalid5),
        .out_dataerror(out_dataerror5), .in_idle(in_idle5), .fill_level(fill_level5),
        .overflow(overflow5)
    );

    // One cycle on the default instance: drive after negedge, sample mid-cycle.
    task automatic step(input logic v, input logic [63:0] d, input logic e);
        in_datavalid = v;
        in_data      = d;
        in_dataerror = e;
        #1;
        if (out_datavalid && in_idle) begin
            cap_d.push_back(out_data);
            cap_e.push_back(out_dataerror);
        end
        @(negedge clk);
    endtask

    // One cycle on the 48->64 instance.
    task automatic step5(input logic v, input logic [47:0] d);
        in_datavalid5 = v;
        in_data5      = d;
        #1;
        if (out_datavalid5 && in_idle5) begin
            cap5_d.push_back(out_data5);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (out_data !== 48'h0) $display("FAIL reset_out_data got=%h want=0", out_data); else passed++;
        total++; if (out_datavalid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_datavalid); else passed++;
        total++; if (out_dataerror !== 1'b0) $display("FAIL reset_err got=%b want=0", out_dataerror); else passed++;
        total++; if (fill_level !== 6'd0) $display("FAIL reset_fill got=%0d want=0", fill_level); else passed++;
        total++; if (out_idle !== 1'b1) $display("FAIL reset_idle got=%b want=1", out_idle); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b want=0", overflow); else passed++;
    endtask

    // Three input beats, four output beats; errbeat selects which beat carries the error flag (-1 = none).
    task automatic run_s1(input int errbeat, input string tag);
        logic [3:0] ee;
        ee = (errbeat == 1) ? exp_err_b1 : 4'b0000;
        cap_d.delete();
        cap_e.delete();
        in_idle = 1'b1;
        for (int b = 0; b < 3; b++) step(1'b1, beats[b], errbeat == b);
        for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b0);
        total++;
        if (cap_d.size() != 4) $display("FAIL %s_count got=%0d want=4", tag, cap_d.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= cap_d.size()) $display("FAIL %s_out%0d got=none want=%h", tag, i, exp_o[i]);
            else if (cap_d[i] !== exp_o[i]) $display("FAIL %s_out%0d got=%h want=%h", tag, i, cap_d[i], exp_o[i]);
            else passed++;
            if (errbeat >= 0) begin
                total++;
                if (i >= cap_e.size()) $display("FAIL %s_err%0d got=none want=%b", tag, i, ee[i]);
                else if (cap_e[i] !== ee[i]) $display("FAIL %s_err%0d got=%b want=%b", tag, i, cap_e[i], ee[i]);
                else passed++;
            end
        end
        total++;
        if (fill_level !== 6'd0) $display("FAIL %s_fill_end got=%0d want=0", tag, fill_level); else passed++;
    endtask

    task automatic test_overflow();
        in_idle = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, {16'(i), 16'(i), 16'(i), 16'(i)}, 1'b0);
        in_datavalid = 1'b0;
        #1;
        total++; if (fill_level !== 6'd40) $display("FAIL ovf_fill40 got=%0d want=40", fill_level); else passed++;
        total++; if (out_idle !== 1'b0) $display("FAIL ovf_idle_full got=%b want=0", out_idle); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_before got=%b want=0", overflow); else passed++;
        step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%b want=1", overflow); else passed++;
        total++; if (fill_level !== 6'd40) $display("FAIL ovf_fill_kept got=%0d want=40", fill_level); else passed++;
        step(1'b0, 64'h0, 1'b0);
        step(1'b0, 64'h0, 1'b0);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", overflow); else passed++;
        flush = 1'b1;
        step(1'b0, 64'h0, 1'b0);
        flush = 1'b0;
        #1;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_flush_clear got=%b want=0", overflow); else passed++;
        total++; if (fill_level !== 6'd0) $display("FAIL ovf_flush_fill got=%0d want=0", fill_level); else passed++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        in_idle = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 64'h1111_2222_3333_4444, 1'b1);
        #1;
        total++; if (fill_level !== 6'd20) $display("FAIL flush_pre_fill got=%0d want=20", fill_level); else passed++;
        in_idle      = 1'b1;
        in_datavalid = 1'b1;
        flush        = 1'b1;
        #1;
        total++; if (out_idle !== 1'b1) $display("FAIL flush_cycle_idle got=%b want=1", out_idle); else passed++;
        total++; if (out_datavalid !== 1'b1) $display("FAIL flush_cycle_valid got=%b want=1", out_datavalid); else passed++;
        @(negedge clk);
        flush        = 1'b0;
        in_datavalid = 1'b0;
        #1;
        total++; if (fill_level !== 6'd0) $display("FAIL flush_fill got=%0d want=0", fill_level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL flush_overflow got=%b want=0", overflow); else passed++;
        total++; if (out_datavalid !== 1'b0) $display("FAIL flush_valid got=%b want=0", out_datavalid); else passed++;
        total++; if (out_dataerror !== 1'b0) $display("FAIL flush_err got=%b want=0", out_dataerror); else passed++;
        @(negedge clk);
    endtask

    task automatic test_ratio();
        logic [63:0] exp;
        cap5_d.delete();
        for (int b = 0; b < 16; b++)
            step5(1'b1, {16'(16'h0100 + 3*b + 2), 16'(16'h0100 + 3*b + 1), 16'(16'h0100 + 3*b)});
        for (int i = 0; i < 3; i++) step5(1'b0, 48'h0);
        total++;
        if (cap5_d.size() != 12) $display("FAIL ratio_count got=%0d want=12", cap5_d.size()); else passed++;
        for (int o = 0; o < 12; o++) begin
            exp = {16'(16'h0100 + 4*o + 3), 16'(16'h0100 + 4*o + 2), 16'(16'h0100 + 4*o + 1), 16'(16'h0100 + 4*o)};
            total++;
            if (o >= cap5_d.size()) $display("FAIL ratio_out%0d got=none want=%h", o, exp);
            else if (cap5_d[o] !== exp) $display("FAIL ratio_out%0d got=%h want=%h", o, cap5_d[o], exp);
            else passed++;
        end
        total++;
        if (fill_level5 !== 5'd0) $display("FAIL ratio_fill_end got=%0d want=0", fill_level5); else passed++;
    endtask

    task automatic test_midreset();
        in_idle = 1'b1;
        step(1'b1, beats[0], 1'b1);
        step(1'b1, beats[1], 1'b1);
        in_datavalid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (out_datavalid !== 1'b0) $display("FAIL mid_reset_valid got=%b want=0", out_datavalid); else passed++;
        total++; if (fill_level !== 6'd0) $display("FAIL mid_reset_fill got=%0d want=0", fill_level); else passed++;
        total++; if (out_data !== 48'h0) $display("FAIL mid_reset_data got=%h want=0", out_data); else passed++;
        total++; if (out_dataerror !== 1'b0) $display("FAIL mid_reset_err got=%b want=0", out_dataerror); else passed++;
        total++; if (out_idle !== 1'b1) $display("FAIL mid_reset_idle got=%b want=1", out_idle); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
        run_s1(-1, "post_reset");
    endtask

    initial begin
        reset_n       = 1'b0;
        in_enable     = 1'b1;
        flush         = 1'b0;
        in_datavalid  = 1'b0;
        in_dataerror  = 1'b0;
        in_idle       = 1'b1;
        in_data       = '0;
        in_enable5    = 1'b1;
        flush5        = 1'b0;
        in_datavalid5 = 1'b0;
        in_dataerror5 = 1'b0;
        in_idle5      = 1'b1;
        in_data5      = '0;
        #3;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_s1(-1, "basic");
        run_s1(1, "error");
        test_overflow();
        test_flush();
        test_ratio();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
